// File: rtl/stream_demux_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the 1-to-N stream demultiplexer.
//   - demux_state_e : packet-tracking FSM state
//   - STATE_W       : state encoding width
//   - chan_base()   : base bit of channel k inside the flattened out_data bus
// Optional feature macro: DEMUX_BCAST_EN (adds the BCAST state).
// ---------------------------------------------------------------------------
package stream_demux_pkg;

    localparam int STATE_W = 2;

`ifdef DEMUX_BCAST_EN
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_DROP  = 2'd2,
        ST_BCAST = 2'd3
    } demux_state_e;
`else
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_DROP  = 2'd2
    } demux_state_e;
`endif

    function automatic int chan_base(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/stream_demux_1xn_chan_reg.sv
// ---------------------------------------------------------------------------
// demux_chan_reg
// One-entry holding register for a single demux output channel.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   ld          - load d/d_last (accepted beat routed here)
//   d, d_last   - incoming payload and packet-end flag
//   rdy         - downstream consumer ready
//   vld         - entry holds a beat
//   q, q_last   - held payload and packet-end flag
//   can_accept  - entry can take a beat this cycle (empty or draining)
// ---------------------------------------------------------------------------
module demux_chan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             d_last,
    input  logic             rdy,
    output logic             vld,
    output logic [WIDTH-1:0] q,
    output logic             q_last,
    output logic             can_accept
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    // A load wins over a drain, so load+drain in one cycle keeps vld set
    // and presents the new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (ld) begin
            vld_q  <= 1'b1;
            data_q <= d;
            last_q <= d_last;
        end else if (vld_q && rdy) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end
    end

    assign vld        = vld_q;
    assign q          = data_q;
    assign q_last     = last_q;
    assign can_accept = !vld_q || rdy;

endmodule

// File: rtl/stream_demux_1xn.sv
// ---------------------------------------------------------------------------
// stream_demux_1xn
// Registered valid/ready 1-to-N stream demultiplexer. The channel select is
// sampled on the packet head and held until the last beat, so a packet never
// splits across channels. Each channel has its own one-entry register, so a
// stalled channel never blocks traffic to the others.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   in_valid/in_ready           - input handshake (in_ready has no path from in_valid)
//   in_data, in_sel, in_last    - payload, head channel select, packet end
//   in_bcast (DEMUX_BCAST_EN)   - head flag: write packet to every channel
//   out_valid/out_ready [N]     - per-channel handshake
//   out_data [N*WIDTH]          - channel k at [k*WIDTH +: WIDTH]
//   out_last [N]                - per-channel packet-end flag
//   drop_err                    - 1-cycle pulse: head addressed channel >= N
// Optional feature macro: DEMUX_BCAST_EN.
//
// state | meaning
// IDLE  | waiting for a packet head; target is in_sel
// LOCK  | inside a packet; target is lock_sel, in_sel ignored
// DROP  | inside a packet with an invalid head; beats discarded
// BCAST | inside a broadcast packet (DEMUX_BCAST_EN only)
// ---------------------------------------------------------------------------
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic               in_bcast,
`endif
    input  logic               in_last,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_last,
    output logic               drop_err
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    demux_state_e     state_q, state_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
    logic             drop_err_q, drop_err_d;

    logic [SEL_W-1:0] tgt_sel;
    logic [N-1:0]     tgt_oh;
    logic [N-1:0]     chan_acc;
    logic [N-1:0]     ld_mask;
    logic [N-1:0]     chan_ld;
    logic             sel_bad;
    logic             bcast_head;
    logic             ready_raw;
    logic             drop_beat;
    logic             accept;

`ifdef DEMUX_BCAST_EN
    assign bcast_head = in_bcast;
`else
    assign bcast_head = 1'b0;
`endif

    // Comparison done one bit wider so a non-power-of-two N can flag
    // out-of-range selects.
    assign sel_bad = ({1'b0, in_sel} >= N_EXT);

    // One-hot target; an out-of-range select decodes to all zeros.
    always_comb begin
        tgt_sel = (state_q == ST_LOCK) ? lock_sel_q : in_sel;
        for (int k = 0; k < N; k++) begin
            tgt_oh[k] = ({1'b0, tgt_sel} == (SEL_W+1)'(k));
        end
    end

    // Readiness and routing depend only on state, select and channel status.
    always_comb begin
        ready_raw = 1'b0;
        ld_mask   = '0;
        drop_beat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bcast_head) begin
                    ready_raw = &chan_acc;
                    ld_mask   = '1;
                end else if (sel_bad) begin
                    ready_raw = 1'b1;
                    drop_beat = 1'b1;
                end else begin
                    ready_raw = |(tgt_oh & chan_acc);
                    ld_mask   = tgt_oh;
                end
            end
            ST_LOCK: begin
                ready_raw = |(tgt_oh & chan_acc);
                ld_mask   = tgt_oh;
            end
            ST_DROP: begin
                ready_raw = 1'b1;
            end
`ifdef DEMUX_BCAST_EN
            ST_BCAST: begin
                ready_raw = &chan_acc;
                ld_mask   = '1;
            end
`endif
            default: begin
                ready_raw = 1'b0;
            end
        endcase
    end

    assign in_ready   = rst_n && ready_raw;
    assign accept     = in_valid && in_ready;
    assign chan_ld    = accept ? ld_mask : '0;
    assign drop_err_d = accept && drop_beat;

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !in_last) begin
                    if (bcast_head) begin
`ifdef DEMUX_BCAST_EN
                        state_d = ST_BCAST;
`endif
                    end else if (sel_bad) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d    = ST_LOCK;
                        lock_sel_d = in_sel;
                    end
                end
            end
            default: begin
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign drop_err = drop_err_q;

    for (genvar k = 0; k < N; k++) begin : g_chan
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .ld         (chan_ld[k]),
            .d          (in_data),
            .d_last     (in_last),
            .rdy        (out_ready[k]),
            .vld        (out_valid[k]),
            .q          (out_data[chan_base(k, WIDTH) +: WIDTH]),
            .q_last     (out_last[k]),
            .can_accept (chan_acc[k])
        );
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
module tb_stream_demux_1xn;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 4-channel instance
    logic        s4_valid, s4_ready, s4_last, s4_drop;
    logic [7:0]  s4_data;
    logic [1:0]  s4_sel;
    logic [3:0]  s4_ovalid, s4_ordy, s4_olast;
    logic [31:0] s4_odata;

    // 3-channel instance (has an unused select code)
    logic        s3_valid, s3_ready, s3_last, s3_drop;
    logic [7:0]  s3_data;
    logic [1:0]  s3_sel;
    logic [2:0]  s3_ovalid, s3_ordy, s3_olast;
    logic [23:0] s3_odata;

`ifdef DEMUX_BCAST_EN
    logic s4_bcast, s3_bcast;
`endif

    stream_demux_1xn #(.WIDTH(8), .N(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s4_valid),
        .in_ready (s4_ready),
        .in_data  (s4_data),
        .in_sel   (s4_sel),
`ifdef DEMUX_BCAST_EN
        .in_bcast (s4_bcast),
`endif
        .in_last  (s4_last),
        .out_valid(s4_ovalid),
        .out_ready(s4_ordy),
        .out_data (s4_odata),
        .out_last (s4_olast),
        .drop_err (s4_drop)
    );

    stream_demux_1xn #(.WIDTH(8), .N(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s3_valid),
        .in_ready (s3_ready),
        .in_data  (s3_data),
        .in_sel   (s3_sel),
`ifdef DEMUX_BCAST_EN
        .in_bcast (s3_bcast),
`endif
        .in_last  (s3_last),
        .out_valid(s3_ovalid),
        .out_ready(s3_ordy),
        .out_data (s3_odata),
        .out_last (s3_olast),
        .drop_err (s3_drop)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dmask(input logic [3:0] v);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (v[k]) m[k*8 +: 8] = 8'hFF;
        return m;
    endfunction

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [1:0]  sel;
        logic        last;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_vld;
        logic [31:0] e_data;
        logic [3:0]  e_last;
    } vec_t;

    vec_t tv[8];

    // reference model state for the 3-channel random run
    bit         hv[3];
    logic [7:0] hd[3];
    bit         hl[3];
    bit         in_pkt;
    int         pkt_tgt;
    bit         m_drop;

    initial begin
        int          t;
        bit          e_rdy;
        logic [3:0]  ev, el;
        logic [31:0] ed;
        int          drop_cnt;
        logic [2:0]  vld_seen;

        tv[0] = '{1'b1, 8'hA5, 2'd2, 1'b1, 4'hF,    1'b1, 4'b0100, 32'h00A5_0000, 4'b0100};
        tv[1] = '{1'b1, 8'h11, 2'd1, 1'b0, 4'hF,    1'b1, 4'b0010, 32'h0000_1100, 4'b0000};
        tv[2] = '{1'b1, 8'h22, 2'd3, 1'b0, 4'hF,    1'b1, 4'b0010, 32'h0000_2200, 4'b0000};
        tv[3] = '{1'b1, 8'h33, 2'd3, 1'b1, 4'hF,    1'b1, 4'b0010, 32'h0000_3300, 4'b0010};
        tv[4] = '{1'b1, 8'h44, 2'd0, 1'b1, 4'b1110, 1'b1, 4'b0001, 32'h0000_0044, 4'b0001};
        tv[5] = '{1'b1, 8'h55, 2'd0, 1'b1, 4'b1110, 1'b0, 4'b0001, 32'h0000_0044, 4'b0001};
        tv[6] = '{1'b1, 8'h5A, 2'd3, 1'b1, 4'b1110, 1'b1, 4'b1001, 32'h5A00_0044, 4'b1001};
        tv[7] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hF,    1'b1, 4'b0000, 32'h0000_0000, 4'b0000};

        rst_n    = 1'b0;
        s4_valid = 1'b1; s4_data = 8'h00; s4_sel = 2'd0; s4_last = 1'b1; s4_ordy = 4'hF;
        s3_valid = 1'b0; s3_data = 8'h00; s3_sel = 2'd0; s3_last = 1'b0; s3_ordy = 3'h7;
`ifdef DEMUX_BCAST_EN
        s4_bcast = 1'b0; s3_bcast = 1'b0;
`endif
        #12;
        check("rst_ready",  s4_ready,  1'b0);
        check("rst_ovalid", s4_ovalid, 4'h0);
        check("rst_odata",  s4_odata,  32'h0);
        check("rst_olast",  s4_olast,  4'h0);
        check("rst_drop",   s4_drop,   1'b0);
        s4_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // table: routing, packet lock, backpressure isolation
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s4_valid = tv[i].v; s4_data = tv[i].d; s4_sel = tv[i].sel;
            s4_last = tv[i].last; s4_ordy = tv[i].ordy;
            #1;
            check("tbl_ready", s4_ready, tv[i].e_rdy);
            @(posedge clk);
            #1;
            check("tbl_valid", s4_ovalid, tv[i].e_vld);
            check("tbl_data",  s4_odata & dmask(s4_ovalid), tv[i].e_data);
            check("tbl_last",  s4_olast & s4_ovalid, tv[i].e_last);
            check("tbl_drop",  s4_drop, 1'b0);
        end

        // invalid select on N=3: two-beat packet, head sel=3
        drop_cnt = 0;
        vld_seen = '0;
        @(negedge clk);
        s3_valid = 1'b1; s3_data = 8'h01; s3_sel = 2'd3; s3_last = 1'b0; s3_ordy = 3'h7;
        #1;
        check("inv_ready_head", s3_ready, 1'b1);
        @(posedge clk);
        #1;
        check("inv_drop_next", s3_drop, 1'b1);
        drop_cnt += int'(s3_drop);
        vld_seen |= s3_ovalid;
        @(negedge clk);
        s3_data = 8'h02; s3_sel = 2'd0; s3_last = 1'b1;
        #1;
        check("inv_ready_tail", s3_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            drop_cnt += int'(s3_drop);
            vld_seen |= s3_ovalid;
            @(negedge clk);
            s3_valid = 1'b0;
        end
        check("inv_drop_cnt", drop_cnt, 1);
        check("inv_no_valid", vld_seen, 3'b000);

        // reset in the middle of a packet to channel 2
        @(negedge clk);
        s4_valid = 1'b1; s4_data = 8'hC1; s4_sel = 2'd2; s4_last = 1'b0; s4_ordy = 4'h0;
        @(posedge clk);
        #1;
        check("rstm_loaded", s4_ovalid, 4'b0100);
        @(negedge clk);
        s4_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstm_ovalid", s4_ovalid, 4'h0);
        check("rstm_ready",  s4_ready,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        s4_valid = 1'b1; s4_data = 8'hD0; s4_sel = 2'd0; s4_last = 1'b1; s4_ordy = 4'hF;
        #1;
        check("rstm_ready_after", s4_ready, 1'b1);
        @(posedge clk);
        #1;
        check("rstm_route_valid", s4_ovalid, 4'b0001);
        check("rstm_route_data",  s4_odata & dmask(s4_ovalid), 32'h0000_00D0);
        @(negedge clk);
        s4_valid = 1'b0;

        // randomized traffic on N=3 against the reference model
        for (int k = 0; k < 3; k++) begin hv[k] = 0; hd[k] = '0; hl[k] = 0; end
        in_pkt = 0; pkt_tgt = 0; m_drop = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            s3_valid = ($urandom_range(0, 3) != 0);
            s3_data  = 8'($urandom);
            s3_sel   = 2'($urandom_range(0, 3));
            s3_last  = ($urandom_range(0, 2) == 0);
            s3_ordy  = 3'($urandom_range(0, 7));
            if (!in_pkt) t = (s3_sel >= 2'd3) ? -1 : int'(s3_sel);
            else         t = pkt_tgt;
            if (t < 0) e_rdy = 1'b1;
            else       e_rdy = !hv[t] || s3_ordy[t];
            ev = '0; ed = '0; el = '0;
            for (int k = 0; k < 3; k++) begin
                if (hv[k]) begin
                    ev[k] = 1'b1;
                    ed[k*8 +: 8] = hd[k];
                    el[k] = hl[k];
                end
            end
            #1;
            check("rnd_ready", s3_ready, e_rdy);
            check("rnd_valid", s3_ovalid, ev[2:0]);
            check("rnd_data",  {8'h00, s3_odata} & dmask({1'b0, s3_ovalid}), ed);
            check("rnd_last",  s3_olast & s3_ovalid, el[2:0]);
            check("rnd_drop",  s3_drop, m_drop);
            @(posedge clk);
            m_drop = 0;
            if (s3_valid && e_rdy) begin
                if (!in_pkt && t < 0) m_drop = 1;
                for (int k = 0; k < 3; k++) begin
                    if (t == k) begin
                        hv[k] = 1; hd[k] = s3_data; hl[k] = s3_last;
                    end else if (hv[k] && s3_ordy[k]) begin
                        hv[k] = 0;
                    end
                end
                if (!in_pkt && !s3_last) begin
                    in_pkt = 1; pkt_tgt = t;
                end else if (in_pkt && s3_last) begin
                    in_pkt = 0;
                end
            end else begin
                for (int k = 0; k < 3; k++) if (hv[k] && s3_ordy[k]) hv[k] = 0;
            end
        end
        @(negedge clk);
        s3_valid = 1'b0;

`ifdef DEMUX_BCAST_EN
        @(negedge clk);
        s4_valid = 1'b1; s4_bcast = 1'b1; s4_data = 8'h7E; s4_sel = 2'd1; s4_last = 1'b1; s4_ordy = 4'hF;
        #1;
        check("bc_ready", s4_ready, 1'b1);
        @(posedge clk);
        #1;
        check("bc_valid", s4_ovalid, 4'hF);
        check("bc_data",  s4_odata, 32'h7E7E_7E7E);
        @(negedge clk);
        s4_data = 8'h7F; s4_ordy = 4'b1101;
        #1;
        check("bc_blocked", s4_ready, 1'b0);
        @(negedge clk);
        s4_valid = 1'b0; s4_bcast = 1'b0;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_demux_1xn.md
# stream_demux_1xn

Parametrised 1-to-N stream demultiplexer. It is the registered, handshaked successor to the gate-level 1x4 demux. A valid/ready input stream carries a channel select and a packet-end marker. Each beat is routed to one of N output channels, and each channel has its own one-entry holding register. The select is locked for the duration of a packet, so multi-beat packets never split across channels. The block sits between a single producer (e.g. a UART/bus receiver) and N independent consumers.

## Interface
Parameters:
- WIDTH, 8, data bits per beat (≥1)
- N, 4, number of output channels (2..16)
- SEL_W, derived localparam $clog2(N), select width; not overridable

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  WIDTH  beat payload
- in_sel  in  SEL_W  target channel; sampled only on the first beat of a packet
- in_last  in  1  final beat of packet
- out_valid  out  N  per-channel beat present
- out_ready  in  N  per-channel consumer ready
- out_data  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_last  out  N  per-channel packet-end flag
- drop_err  out  1  one-cycle pulse, packet head addressed a nonexistent channel

## Operation
- Each channel has a holding register {valid, data, last}. It loads on an accepted beat routed to it and clears when out_valid[k] && out_ready[k] with no new load. Load and drain in the same cycle keep valid=1 and take the new data.
- Channel k can accept when !valid[k] || out_ready[k].
- FSM states: IDLE, LOCK, DROP.
  - IDLE: target is in_sel. An accepted beat with in_last=0 moves to LOCK (target latched into lock_sel) or to DROP if in_sel ≥ N. An accepted beat with in_last=1 stays in IDLE.
  - LOCK: target is lock_sel and in_sel is ignored. An accepted beat with in_last=1 returns to IDLE.
  - DROP: in_ready=1 and beats are discarded. An accepted beat with in_last=1 returns to IDLE.
- in_sel ≥ N on a packet head: in_ready=1, the beat is discarded, and drop_err pulses the following cycle. This happens once per dropped packet, including single-beat packets.
- in_ready is combinational from state, in_sel, channel valid and out_ready. It has no combinational path from in_valid.
- Channels are fully independent. A stalled channel never blocks a beat routed to another channel.

## Timing
- Reset: out_valid=0, out_data=0, out_last=0, drop_err=0, FSM=IDLE, lock_sel=0. in_ready is forced to 0 while rst_n=0.
- Reset asserted mid-packet aborts the packet immediately. Held channel beats are lost. After release, the FSM is in IDLE.
- Latency: accepted beat appears on out_* on the next rising edge.
- Throughput: 1 beat/cycle into a channel whose consumer holds out_ready=1.
- out_data[k] and out_last[k] stay stable while out_valid[k]=1 && out_ready[k]=0.

## Configuration
- DEMUX_BCAST_EN defined: adds input port in_bcast (1 bit, sampled with in_sel on the packet head).
  - With in_bcast=1, the packet is written to all N channels. in_ready requires every channel able to accept.
  - The FSM adds state BCAST, which exits on an accepted last beat.
  - in_sel is ignored during broadcast.
- DEMUX_BCAST_EN undefined: no in_bcast port and no BCAST state. Behaviour is exactly as above.

## Structure
- Package stream_demux_pkg holds:
  - the FSM state enum typedef (IDLE, LOCK, DROP, BCAST under the macro)
  - constants for state encoding width
  - a helper function that computes the channel bit-slice base.
- Sub-module demux_chan_reg is instantiated N times. It is the one-entry holding register with load/drain logic, parametrised on WIDTH, and has ports clk, rst_n, ld, d, d_last, rdy, vld, q, q_last, can_accept.

## Test plan
- Single-beat routing: N=4, send data 0xA5 sel=2 last=1 with all out_ready=1 → next cycle out_valid=4'b0100, channel 2 data 0xA5, last=1. Other channels stay idle.
- Packet lock: send a 3-beat packet 0x11/0x22/0x33 with sel=1 on the head and sel=3 on beats 2–3 → all three beats go to channel 1 and out_last is set on 0x33 only.
- Backpressure isolation: hold out_ready[0]=0 with channel 0 full, then send a beat to channel 0 → in_ready=0. Then send a beat to channel 3 → accepted, and 0x5A appears on channel 3 next cycle.
- Invalid select: N=3, head sel=3 on a 2-beat packet → both beats accepted, no out_valid rises, and drop_err is high for exactly 1 cycle.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 4-beat packet to channel 2 → out_valid=0 immediately. After release, a new head with sel=0 routes to channel 0.
- Broadcast (DEMUX_BCAST_EN): in_bcast=1, 0x7E, last=1 → out_valid=4'b1111, all channels 0x7E. With out_ready[1]=0 and channel 1 full, in_ready=0.
